// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: access tag enum, RAM read/write encodings, default bus widths.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 32;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Identifies which requester owns an access travelling through the pipe.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

endpackage

// File: rtl/arb_tag_pipe.sv
// Tracks the owner of each RAM access and steers the returning read data.
// Latency: a tag entered at cycle T shows up as a valid pulse at T+2.
// Backpressure: none; a new tag (or TAG_NONE) enters every cycle.
// Ports:
//   clk, reset      - clock, async active-low clear of both stages
//   tag_i, we_i     - owner of this cycle's grant and its store bit
//   ram_rdata_i     - registered RAM read data, aligned with stage 2
//   if_valid_o/if_rdata_o, d_valid_o/d_rdata_o - per-port responses
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  tag_e              tag_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              d_valid_o,
  output logic [DATA_W-1:0] d_rdata_o
);

  tag_e tag1_q, tag2_q;
  logic we1_q, we2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag1_q <= TAG_NONE;
      tag2_q <= TAG_NONE;
      we1_q  <= RW_READ;
      we2_q  <= RW_READ;
    end else begin
      tag1_q <= tag_i;
      we1_q  <= we_i;
      tag2_q <= tag1_q;
      we2_q  <= we1_q;
    end
  end

  assign if_valid_o = (tag2_q == TAG_IF);
  assign d_valid_o  = (tag2_q == TAG_D);

  // Data buses stay at zero outside a response so downstream never sees
  // stale RAM contents; a store acknowledge also returns zero.
  assign if_rdata_o = if_valid_o ? ram_rdata_i : '0;
  assign d_rdata_o  = (d_valid_o && (we2_q == RW_READ)) ? ram_rdata_i : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported RAM between instruction fetch and load/store.
// Latency: grant at T, RAM access at T+1, valid + data at T+2; one access/cycle.
// Backpressure: a requester without a grant must hold req and its inputs;
//   nothing is latched until the grant cycle.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to let fetch win after
//   STARVE_LIMIT consecutive data grants; otherwise data has strict priority.
// Ports:
//   clk, reset                     - clock, async active-low reset
//   if_req/if_addr -> if_gnt       - fetch request and combinational grant
//   if_valid/if_rdata              - fetch response
//   d_req/d_we/d_addr/d_wdata -> d_gnt - load/store request and grant
//   d_valid/d_rdata                - load data or store acknowledge
//   ram_rw/ram_addr/ram_wdata      - registered RAM command
//   ram_rdata                      - RAM read data (one cycle after access)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
  end

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic starve_fire;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  // Fires only under real contention; a lone fetch wins on its own anyway.
  assign starve_fire = if_req && d_req && (starve_q == 4'(STARVE_LIMIT));

  // Counts data grants that made a waiting fetch wait; since it fires (and
  // clears) at the limit it never needs to saturate.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (d_gnt) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  assign if_gnt = if_req && (!d_req || starve_fire);
  assign d_gnt  = d_req && !if_gnt;

  // ---------------------------------------------------------------------
  // Issue register
  // ---------------------------------------------------------------------
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Idle cycles force a read so a store is never repeated; address and
  // write data simply hold to avoid needless toggling on the RAM pins.
  always_comb begin
    rw_d    = RW_READ;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (d_gnt) begin
      rw_d    = d_we ? RW_WRITE : RW_READ;
      addr_d  = d_addr;
      wdata_d = d_wdata;
    end else if (if_gnt) begin
      addr_d  = if_addr;
    end
  end

  // Async reset clears rw immediately, dropping any store already latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ram_rw    = rw_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  // ---------------------------------------------------------------------
  // Response tagging
  // ---------------------------------------------------------------------
  tag_e win_tag;
  logic win_we;

  always_comb begin
    win_tag = TAG_NONE;
    if (d_gnt) begin
      win_tag = TAG_D;
    end else if (if_gnt) begin
      win_tag = TAG_IF;
    end
  end

  assign win_we = d_gnt && d_we;

  arb_tag_pipe #(
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .clk         (clk),
    .reset       (reset),
    .tag_i       (win_tag),
    .we_i        (win_we),
    .ram_rdata_i (ram_rdata),
    .if_valid_o  (if_valid),
    .if_rdata_o  (if_rdata),
    .d_valid_o   (d_valid),
    .d_rdata_o   (d_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM, a shadow memory
// model and an in-order response scoreboard.
module tb_mem_port_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit            is_d;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] ram_mem [int];
    logic [DW-1:0] shadow  [int];

    function automatic void chk(input string tag, input bit ok,
                                input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM: read data registered, old value on write.
    always @(posedge clk) begin
        ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : '0;
        if (ram_rw === 1'b1) ram_mem[int'(ram_addr)] = ram_wdata;
    end

    function automatic logic [DW-1:0] rd_shadow(input int a);
        return shadow.exists(a) ? shadow[a] : '0;
    endfunction

    // Monitor: checks responses against the scoreboard, then records grants.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (if_valid || d_valid) begin
                chk("one_valid", (if_valid && d_valid) === 1'b0, (if_valid && d_valid), 1'b0);
                chk("sb_nonempty", (sb.size() > 0) === 1'b1, (sb.size() > 0), 1'b1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("resp_port", d_valid === mon_e.is_d, d_valid, mon_e.is_d);
                    chk("resp_data", (mon_e.is_d ? d_rdata : if_rdata) === mon_e.data,
                        (mon_e.is_d ? d_rdata : if_rdata), mon_e.data);
                    chk("resp_cycle", cyc == mon_e.due, cyc, mon_e.due);
                end
            end
            if (if_gnt || d_gnt) begin
                chk("gnt_excl", (if_gnt && d_gnt) === 1'b0, (if_gnt && d_gnt), 1'b0);
                mon_e.due = cyc + 2;
                if (d_gnt) begin
                    mon_e.is_d = 1'b1;
                    if (d_we) begin
                        shadow[int'(d_addr)] = d_wdata;
                        mon_e.data = '0;
                    end else begin
                        mon_e.data = rd_shadow(int'(d_addr));
                    end
                end else begin
                    mon_e.is_d = 1'b0;
                    mon_e.data = rd_shadow(int'(if_addr));
                end
                sb.push_back(mon_e);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) next();
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = a;
        d_wdata = d;
        @(negedge clk);
        chk("preload_gnt", d_gnt === 1'b1, d_gnt, 1'b1);
        next();
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    initial begin
        logic exp_if;
        reset   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_rw", ram_rw === 1'b0, ram_rw, 1'b0);
        chk("rst_ram_addr", ram_addr === 16'h0000, ram_addr, 16'h0000);
        chk("rst_ram_wdata", ram_wdata === 32'h0, ram_wdata, 32'h0);
        chk("rst_if_valid", if_valid === 1'b0, if_valid, 1'b0);
        chk("rst_d_valid", d_valid === 1'b0, d_valid, 1'b0);
        chk("rst_if_rdata", if_rdata === 32'h0, if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata === 32'h0, d_rdata, 32'h0);
        chk("rst_no_gnt", (if_gnt || d_gnt) === 1'b0, (if_gnt || d_gnt), 1'b0);
        reset = 1'b1;
        next();

        // Preload through the store path (back-to-back grants)
        do_store(16'h0010, 32'hDEADBEEF);
        do_store(16'h0020, 32'hA5A50020);
        do_store(16'h0044, 32'h11110044);
        idle(3);

        // Fetch only
        if_req  = 1'b1;
        if_addr = 16'h0010;
        @(negedge clk);
        chk("fo_if_gnt", if_gnt === 1'b1, if_gnt, 1'b1);
        chk("fo_d_gnt", d_gnt === 1'b0, d_gnt, 1'b0);
        next();
        if_req = 1'b0;
        @(negedge clk);
        chk("fo_ram_addr", ram_addr === 16'h0010, ram_addr, 16'h0010);
        chk("fo_ram_rw", ram_rw === 1'b0, ram_rw, 1'b0);
        next();
        @(negedge clk);
        chk("fo_if_valid", if_valid === 1'b1, if_valid, 1'b1);
        chk("fo_if_rdata", if_rdata === 32'hDEADBEEF, if_rdata, 32'hDEADBEEF);
        next();
        idle(2);

        // Contention: data wins first, fetch next cycle
        if_req  = 1'b1;
        if_addr = 16'h0044;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0020;
        @(negedge clk);
        chk("ct_d_gnt", d_gnt === 1'b1, d_gnt, 1'b1);
        chk("ct_if_gnt0", if_gnt === 1'b0, if_gnt, 1'b0);
        next();
        d_req = 1'b0;
        @(negedge clk);
        chk("ct_if_gnt1", if_gnt === 1'b1, if_gnt, 1'b1);
        next();
        if_req = 1'b0;
        @(negedge clk);
        chk("ct_d_valid", d_valid === 1'b1, d_valid, 1'b1);
        chk("ct_d_rdata", d_rdata === 32'hA5A50020, d_rdata, 32'hA5A50020);
        chk("ct_if_valid_early", if_valid === 1'b0, if_valid, 1'b0);
        next();
        @(negedge clk);
        chk("ct_if_valid", if_valid === 1'b1, if_valid, 1'b1);
        chk("ct_if_rdata", if_rdata === 32'h11110044, if_rdata, 32'h11110044);
        chk("ct_d_valid_late", d_valid === 1'b0, d_valid, 1'b0);
        next();
        idle(2);

        // Store then load, same address, back-to-back
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0030;
        d_wdata = 32'h12345678;
        @(negedge clk);
        chk("sl_st_gnt", d_gnt === 1'b1, d_gnt, 1'b1);
        next();
        d_we = 1'b0;
        @(negedge clk);
        chk("sl_ld_gnt", d_gnt === 1'b1, d_gnt, 1'b1);
        chk("sl_rw_wr", ram_rw === 1'b1, ram_rw, 1'b1);
        chk("sl_addr", ram_addr === 16'h0030, ram_addr, 16'h0030);
        chk("sl_wdata", ram_wdata === 32'h12345678, ram_wdata, 32'h12345678);
        next();
        d_req = 1'b0;
        @(negedge clk);
        chk("sl_rw_rd", ram_rw === 1'b0, ram_rw, 1'b0);
        chk("sl_ack_valid", d_valid === 1'b1, d_valid, 1'b1);
        chk("sl_ack_rdata", d_rdata === 32'h0, d_rdata, 32'h0);
        next();
        @(negedge clk);
        chk("sl_ld_valid", d_valid === 1'b1, d_valid, 1'b1);
        chk("sl_ld_rdata", d_rdata === 32'h12345678, d_rdata, 32'h12345678);
        next();
        idle(2);

        // Sustained contention: starvation guard behaviour
        if_req  = 1'b1;
        if_addr = 16'h0044;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0020;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = ((i % (LIMIT + 1)) == LIMIT);
`else
            exp_if = 1'b0;
`endif
            @(negedge clk);
            chk("sv_if_gnt", if_gnt === exp_if, if_gnt, exp_if);
            chk("sv_d_gnt", d_gnt === !exp_if, d_gnt, !exp_if);
            next();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        idle(3);

        // Reset while a store is sitting in the issue register
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0050;
        d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rm_gnt", d_gnt === 1'b1, d_gnt, 1'b1);
        next();
        d_req = 1'b0;
        d_we  = 1'b0;
        chk("rm_rw_pre", ram_rw === 1'b1, ram_rw, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("rm_rw_async", ram_rw === 1'b0, ram_rw, 1'b0);
        sb.delete();
        shadow.delete(32'h50);
        next();
        next();
        chk("rm_ram_addr", ram_addr === 16'h0000, ram_addr, 16'h0000);
        chk("rm_ram_wdata", ram_wdata === 32'h0, ram_wdata, 32'h0);
        chk("rm_valids", (if_valid || d_valid) === 1'b0, (if_valid || d_valid), 1'b0);
        chk("rm_rdata", (if_rdata | d_rdata) === 32'h0, (if_rdata | d_rdata), 32'h0);
        reset = 1'b1;
        idle(4);
        chk("rm_no_write", ram_mem.exists(32'h50) == 0, ram_mem.exists(32'h50), 1'b0);

        // Idle: park the address at 0x0010 first, then watch for 10 cycles
        if_req  = 1'b1;
        if_addr = 16'h0010;
        @(negedge clk);
        chk("id_setup_gnt", if_gnt === 1'b1, if_gnt, 1'b1);
        next();
        if_req = 1'b0;
        idle(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("id_no_gnt", (if_gnt || d_gnt) === 1'b0, (if_gnt || d_gnt), 1'b0);
            chk("id_rw", ram_rw === 1'b0, ram_rw, 1'b0);
            chk("id_addr", ram_addr === 16'h0010, ram_addr, 16'h0010);
            chk("id_no_valid", (if_valid || d_valid) === 1'b0, (if_valid || d_valid), 1'b0);
            next();
        end

        chk("sb_drained", sb.size() == 0, sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the processor's single-ported 32-bit RAM between the instruction-fetch path and the load/store path. It grants at most one access per cycle and drives the RAM's `rw`, `address` and write-data pins from registers. It tags each in-flight access and returns read data or write acknowledge to the originating requester two cycles after grant. It sits between `ram` on one side and the fetch unit and memory control unit on the other.

## Interface
**Parameters**
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 32: RAM data width.
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits. Only used with `MEM_ARB_STARVE_GUARD_EN`. Legal range 1–15.

**Ports**
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  fetch accepted this cycle (combinational).
- `if_valid`  out  1  fetch data valid (one-cycle pulse).
- `if_rdata`  out  DATA_W  fetch data.
- `d_req`  in  1  load/store request; held with `d_we`, `d_addr` and `d_wdata` stable until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_valid`  out  1  load data valid or store acknowledge (one-cycle pulse).
- `d_rdata`  out  DATA_W  load data.
- `ram_rw`  out  1  to RAM `rw`; 1 = write, 0 = read.
- `ram_addr`  out  ADDR_W  to RAM `address`.
- `ram_wdata`  out  DATA_W  to RAM `data_in`.
- `ram_rdata`  in  DATA_W  from RAM `data_out`. Registered by the RAM; valid the cycle after the access.

## Operation
- **Arbitration** (every cycle, combinational):
  - Only one request pending: it wins.
  - Both pending: data wins, unless the starvation guard fires.
  - At most one of `if_gnt`/`d_gnt` is high.
  - No request pending: no grant.
- **Issue register:** on the edge ending a grant cycle, the winner's address, write enable (0 for fetch) and write data load into `ram_addr`/`ram_rw`/`ram_wdata`.
  - Cycle with no grant: `ram_rw` is forced to 0, `ram_addr` holds its value, `ram_wdata` holds its value.
- **Tag pipeline:** two stages, each holding one of NONE, IF, D, written with the winner (or NONE) each cycle.
  - Stage 2 = IF: `if_valid` = 1.
  - Stage 2 = D: `d_valid` = 1.
- **Read data:** `if_rdata` = `ram_rdata` when `if_valid`, else 0. `d_rdata` = `ram_rdata` when `d_valid` and the access was a load, else 0.
- **Store acknowledge:** a store still pulses `d_valid`, with `d_rdata` = 0.
- **Reset:** asserting `reset` at any time clears both tag stages. Accesses granted before reset never produce `valid`. A write already latched in the issue register is dropped: `ram_rw` goes to 0 asynchronously.

## Timing
- **Reset values:** `ram_rw`=0, `ram_addr`=0, `ram_wdata`=0, `if_valid`=0, `d_valid`=0, `if_rdata`=0, `d_rdata`=0, tags = NONE, starvation counter = 0.
- **Latency:** request granted in cycle T → RAM access in T+1 → `valid` in T+2.
- **Throughput:** one access per cycle; back-to-back grants are allowed with no bubble.
- **Stalled requests:** a requester whose `req` is high without `gnt` must hold its inputs; the arbiter does not latch them.
- **Withdrawal:** `req` dropping before `gnt` is legal; nothing is issued.
- **Responses:** return strictly in grant order.

## Configuration
- **`MEM_ARB_STARVE_GUARD_EN` defined:**
  - A 4-bit counter increments on each `d_gnt` issued while `if_req` is high.
  - When the counter equals `STARVE_LIMIT` and both requests are pending, fetch wins and the counter clears.
  - The counter also clears on any `if_gnt`, and on any cycle with `if_req` low.
- **Not defined:** strict data priority; fetch can be starved indefinitely. No counter is present.

## Structure
- **Shared package `mem_arb_pkg`:**
  - Port tag enum: `TAG_NONE`, `TAG_IF`, `TAG_D`.
  - Constants `RW_READ`=0 and `RW_WRITE`=1.
  - Default `ADDR_W`/`DATA_W`.
- **Sub-module `arb_tag_pipe`:** 2-deep tag shift register with async active-low clear, plus a stored load/store bit. It produces the per-port `valid` and read-data gating.
- **Top level:** arbitration logic, issue register and starvation counter.

## Test plan
- **Fetch only:** `if_req`=1, `if_addr`=0x0010, RAM[0x10]=0xDEADBEEF → `if_gnt` in T, `ram_addr`=0x0010 and `ram_rw`=0 in T+1, `if_valid`=1 with `if_rdata`=0xDEADBEEF in T+2.
- **Contention:** `if_req` and `d_req` (load, 0x0020) both high in T → `d_gnt`=1, `if_gnt`=0 in T; fetch is granted in T+1; `d_valid` in T+2, `if_valid` in T+3.
- **Store then load, same address:** store 0x12345678 to 0x0030, then load 0x0030 back-to-back → `ram_rw`=1 in T+1 and 0 in T+2; `d_valid` in T+2 and T+3; second `d_rdata`=0x12345678.
- **Starvation guard on, `STARVE_LIMIT`=4:** `d_req` and `if_req` held high → 4 data grants, then `if_gnt` on the 5th cycle. Guard off: `if_gnt` never fires while `d_req` is high.
- **Reset mid-flight:** grant a store in T, assert `reset` in T+1 → `ram_rw`=0 immediately; no `d_valid` after reset release; all outputs at reset values.
- **Idle:** no requests for 10 cycles → no `gnt`, `ram_rw`=0 throughout, no `valid` pulses, `ram_addr` unchanged.
